tapasco_reset_sequencer: RTL and testbench
==========================================

# tapasco_reset_sequencer

Single-clock reset sequencer that drives the design and memory reset nets feeding the clock/reset master bridge. It performs an ordered power-on release and software-requested re-resets of the memory and design domains. Interconnect resets are released before peripheral resets, and the memory peripheral waits for memory calibration. Outputs are registered levels in the host clock domain; each target domain re-synchronizes them locally.

## Interface

Parameters:
- HOLD_CYCLES, 16: cycles all resets stay asserted in ASSERT; legal range is at least 1.
- GAP_CYCLES, 8: cycles between consecutive release steps; legal range is at least 1.
- CAL_TIMEOUT, 65535: maximum cycles spent waiting in MEM_CAL; used only with the timeout macro.
- CNT_W, 16: counter width; must hold the largest of the three counts above.

Ports:
- i_host_clk, input, 1: sole clock.
- i_host_peripheral_resetn, input, 1: asynchronous, active-low block reset.
- i_req, input, 1: re-reset request; accepted on a cycle where i_req && o_ready.
- i_mem_calib_done, input, 1: memory calibration complete; already synchronous to i_host_clk.
- o_ready, output, 1: high only in IDLE.
- o_ack, output, 1: one-cycle pulse when a requested sequence completes.
- o_error, output, 1: sticky flag for calibration timeout.
- o_mem_interconnect_resetn, output, 1: memory interconnect reset, active-low.
- o_mem_peripheral_resetn, output, 1: memory peripheral reset, active-low.
- o_mem_peripheral_reset, output, 1: memory peripheral reset, active-high; always ~o_mem_peripheral_resetn.
- o_design_interconnect_resetn, output, 1: design interconnect reset, active-low.
- o_design_peripheral_resetn, output, 1: design peripheral reset, active-low.
- o_design_peripheral_reset, output, 1: design peripheral reset, active-high; always ~o_design_peripheral_resetn.

## Operation

- States: ASSERT, MEM_IC, MEM_CAL, MEM_PER, DES_IC, DES_PER, IDLE.
- Async reset forces state ASSERT.
  - All resetn outputs 0; all reset outputs 1.
  - o_ready=0, o_ack=0, o_error=0; counter=0.
- The first sequence runs automatically after reset deassertion (power-on). o_ack stays 0 for this sequence.
- ASSERT: all resets asserted for HOLD_CYCLES cycles, then go to MEM_IC and release o_mem_interconnect_resetn.
- MEM_IC: wait GAP_CYCLES cycles, then go to MEM_CAL.
- MEM_CAL: on the first cycle with i_mem_calib_done=1, release the memory peripheral pair and go to MEM_PER.
- MEM_PER: wait GAP_CYCLES cycles, then release o_design_interconnect_resetn and go to DES_IC.
- DES_IC: wait GAP_CYCLES cycles, then release the design peripheral pair and go to DES_PER.
- DES_PER: lasts one cycle, then IDLE.
- IDLE: o_ready=1. An accepted i_req re-asserts all six resets on the next edge, enters ASSERT, and clears o_ready.
- o_ack fires on the edge where the design peripheral is released, but only if the sequence was started by i_req.
- i_req while o_ready=0 is ignored; it is not queued.
- i_mem_calib_done falling outside MEM_CAL is ignored.
- Counter rule: it loads N-1 on state entry and the state exits on the edge after the count reaches 0, so the state lasts exactly N cycles. Arithmetic is unsigned with no wrap.
- Async reset mid-sequence: all outputs return to reset values immediately, without waiting for a clock edge, and the power-on sequence restarts.
- o_error clears only on async reset or on acceptance of a new i_req.

## Timing

Edges are counted from the first rising edge of i_host_clk after i_host_peripheral_resetn deasserts, which is edge 1.
- o_mem_interconnect_resetn rises at edge HOLD_CYCLES+1.
- With calibration already done, the memory peripheral pair changes at mem_ic_edge+GAP_CYCLES+1.
- o_design_interconnect_resetn rises at mem_per_edge+GAP_CYCLES.
- The design peripheral pair changes at des_ic_edge+GAP_CYCLES.
- o_ready rises one edge after the design peripheral release.
- For a request accepted at edge R:
  - resets assert at R, in ASSERT;
  - mem IC releases at R+HOLD_CYCLES;
  - later steps use the same spacing as power-on.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- RESET_SEQ_TIMEOUT_EN defined:
  - MEM_CAL counts up to CAL_TIMEOUT cycles.
  - On expiry, o_error is set and the sequence proceeds as if calibration completed.
- RESET_SEQ_TIMEOUT_EN undefined:
  - MEM_CAL waits indefinitely.
  - o_error is tied to 0 and no timeout counter logic is built.

## Test plan

Parameters for all scenarios: HOLD=4, GAP=2, CAL_TIMEOUT=10.
1. Power-on with calib tied high -> mem IC rises at edge 5, mem peripheral at edge 8, design IC at edge 10, design peripheral at edge 12, o_ready=1 from edge 13, o_ack never pulses.
2. Calib raised at edge 20 -> mem peripheral released at edge 20, design IC at edge 22, design peripheral at edge 24.
3. With the macro defined, calib held low -> o_error=1 and mem peripheral released 10 cycles after MEM_CAL entry; a following i_req clears o_error. With the macro undefined -> sequence stalls in MEM_CAL and o_error stays 0.
4. From IDLE, one-cycle i_req at edge R -> all resets asserted at R, o_ready=0, o_ack single pulse coinciding with the design peripheral release; a second i_req mid-sequence has no effect.
5. Async reset asserted during DES_IC -> all resetn outputs 0 and o_ready=0 with no clock edge needed; after release, the power-on timing of scenario 1 repeats.
6. Every cycle of every scenario -> each *_peripheral_reset equals ~*_peripheral_resetn, and design outputs never release before the memory peripheral.

Source files
------------

// File: rtl/tapasco_reset_sequencer_if.sv
// Host-side request/status handshake of the reset sequencer.
// The host pulses i_req while o_ready is high and watches o_ack and o_error.
interface tapasco_reset_sequencer_if;
  logic i_req;
  logic o_ready;
  logic o_ack;
  logic o_error;

  modport master (output i_req, input o_ready, input o_ack, input o_error);
  modport slave  (input i_req, output o_ready, output o_ack, output o_error);
endinterface

// File: rtl/tapasco_reset_sequencer.sv
// Ordered release of memory and design reset nets: interconnect before peripheral, memory before design.
// Optional calibration timeout is built when RESET_SEQ_TIMEOUT_EN is defined.
module tapasco_reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CAL_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                      i_host_clk,
  input  logic                      i_host_peripheral_resetn,
  input  logic                      i_mem_calib_done,
  tapasco_reset_sequencer_if.slave  ctrl,
  output logic                      o_mem_interconnect_resetn,
  output logic                      o_mem_peripheral_resetn,
  output logic                      o_mem_peripheral_reset,
  output logic                      o_design_interconnect_resetn,
  output logic                      o_design_peripheral_resetn,
  output logic                      o_design_peripheral_reset
);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_MEM_IC  = 3'd1,
    ST_MEM_CAL = 3'd2,
    ST_MEM_PER = 3'd3,
    ST_DES_IC  = 3'd4,
    ST_DES_PER = 3'd5,
    ST_IDLE    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LD   = CNT_W'(CAL_TIMEOUT - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  // armed_r is low only between async reset and the first edge, where the power-on hold count is loaded
  logic             armed_r, armed_s;
  logic             req_seq_r, req_seq_s;
  logic             mem_ic_r, mem_ic_s;
  logic             mem_per_r, mem_per_s;
  logic             des_ic_r, des_ic_s;
  logic             des_per_r, des_per_s;
  logic             ready_r, ready_s;
  logic             ack_r, ack_s;
`ifdef RESET_SEQ_TIMEOUT_EN
  logic             err_r, err_s;
`endif

  // Next-state and next-output decode of the release sequence
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    armed_s   = armed_r;
    req_seq_s = req_seq_r;
    mem_ic_s  = mem_ic_r;
    mem_per_s = mem_per_r;
    des_ic_s  = des_ic_r;
    des_per_s = des_per_r;
    ready_s   = ready_r;
    ack_s     = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    err_s     = err_r;
`endif
    case (state_r)
      ST_ASSERT: begin
        if (!armed_r) begin
          armed_s = 1'b1;
          cnt_s   = HOLD_LD;
        end else if (cnt_r == CNT_ZERO) begin
          state_s  = ST_MEM_IC;
          cnt_s    = GAP_LD;
          mem_ic_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_MEM_IC: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_MEM_CAL;
          cnt_s   = CAL_LD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_MEM_CAL: begin
        if (i_mem_calib_done) begin
          state_s   = ST_MEM_PER;
          cnt_s     = GAP_LD;
          mem_per_s = 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
        end else if (cnt_r == CNT_ZERO) begin
          state_s   = ST_MEM_PER;
          cnt_s     = GAP_LD;
          mem_per_s = 1'b1;
          err_s     = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
`else
        end else begin
          cnt_s = cnt_r;
        end
`endif
      end
      ST_MEM_PER: begin
        if (cnt_r == CNT_ZERO) begin
          state_s  = ST_DES_IC;
          cnt_s    = GAP_LD;
          des_ic_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DES_IC: begin
        if (cnt_r == CNT_ZERO) begin
          state_s   = ST_DES_PER;
          des_per_s = 1'b1;
          ack_s     = req_seq_r;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DES_PER: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
      ST_IDLE: begin
        if (ctrl.i_req) begin
          state_s   = ST_ASSERT;
          cnt_s     = HOLD_LD;
          req_seq_s = 1'b1;
          mem_ic_s  = 1'b0;
          mem_per_s = 1'b0;
          des_ic_s  = 1'b0;
          des_per_s = 1'b0;
          ready_s   = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
          err_s     = 1'b0;
`endif
        end else begin
          ready_s = 1'b1;
        end
      end
      default: begin
        state_s   = ST_ASSERT;
        cnt_s     = HOLD_LD;
        mem_ic_s  = 1'b0;
        mem_per_s = 1'b0;
        des_ic_s  = 1'b0;
        des_per_s = 1'b0;
        ready_s   = 1'b0;
      end
    endcase
  end

  // State, counter and registered reset levels
  always_ff @(posedge i_host_clk or negedge i_host_peripheral_resetn) begin
    if (!i_host_peripheral_resetn) begin
      state_r   <= ST_ASSERT;
      cnt_r     <= CNT_ZERO;
      armed_r   <= 1'b0;
      req_seq_r <= 1'b0;
      mem_ic_r  <= 1'b0;
      mem_per_r <= 1'b0;
      des_ic_r  <= 1'b0;
      des_per_r <= 1'b0;
      ready_r   <= 1'b0;
      ack_r     <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      armed_r   <= armed_s;
      req_seq_r <= req_seq_s;
      mem_ic_r  <= mem_ic_s;
      mem_per_r <= mem_per_s;
      des_ic_r  <= des_ic_s;
      des_per_r <= des_per_s;
      ready_r   <= ready_s;
      ack_r     <= ack_s;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_r     <= err_s;
`endif
    end
  end

  assign o_mem_interconnect_resetn    = mem_ic_r;
  assign o_mem_peripheral_resetn      = mem_per_r;
  assign o_mem_peripheral_reset       = ~mem_per_r;
  assign o_design_interconnect_resetn = des_ic_r;
  assign o_design_peripheral_resetn   = des_per_r;
  assign o_design_peripheral_reset    = ~des_per_r;
  assign ctrl.o_ready                 = ready_r;
  assign ctrl.o_ack                   = ack_r;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign ctrl.o_error                 = err_r;
`else
  assign ctrl.o_error                 = 1'b0;
`endif

endmodule

// File: tb/tb_tapasco_reset_sequencer.sv
// Directed bench for tapasco_reset_sequencer: per-edge expected output vectors are queued when
// stimulus is applied and compared as the edges occur; polarity/ordering invariants every cycle.
module tb_tapasco_reset_sequencer;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int CAL  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib = 1'b1;
  logic mem_ic_n, mem_per_n, mem_per_rst, des_ic_n, des_per_n, des_per_rst;
  logic [6:0] obs_vec;
  int edge_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  int req_edge;

  typedef struct {
    int         edge_n;
    logic [6:0] exp_vec;
  } exp_t;
  exp_t sb_q[$];

  tapasco_reset_sequencer_if host_if();

  tapasco_reset_sequencer #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CAL_TIMEOUT(CAL), .CNT_W(16)
  ) dut (
    .i_host_clk                   (clk),
    .i_host_peripheral_resetn     (rst_n),
    .i_mem_calib_done             (calib),
    .ctrl                         (host_if),
    .o_mem_interconnect_resetn    (mem_ic_n),
    .o_mem_peripheral_resetn      (mem_per_n),
    .o_mem_peripheral_reset       (mem_per_rst),
    .o_design_interconnect_resetn (des_ic_n),
    .o_design_peripheral_resetn   (des_per_n),
    .o_design_peripheral_reset    (des_per_rst)
  );

  always #5 clk = ~clk;

  assign obs_vec = {host_if.o_ready, host_if.o_ack, host_if.o_error,
                    mem_ic_n, mem_per_n, des_ic_n, des_per_n};

  // Edge 1 is the first rising edge after reset release
  always @(posedge clk) edge_cnt <= rst_n ? edge_cnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected output vector for every edge from base up to the end of the sequence
  task automatic push_seq(input int base, input bit by_req, input int cal_edge, input int stop);
    int mic, mper, dic, dper, last, err_edge;
    exp_t t;
    mic = base + HOLD;
    err_edge = 1 << 30;
    if (cal_edge == 0) mper = mic + GAP + 1;
    else if (cal_edge > 0) mper = (cal_edge > mic + GAP + 1) ? cal_edge : mic + GAP + 1;
    else begin
`ifdef RESET_SEQ_TIMEOUT_EN
      mper = mic + GAP + CAL;
      err_edge = mper;
`else
      mper = 1 << 30;
`endif
    end
    dic = mper + GAP;
    dper = dic + GAP;
    last = (stop > 0) ? stop : dper + 1;
    for (int e = base; e <= last; e++) begin
      t.edge_n = e;
      t.exp_vec = {e > dper, by_req && (e == dper), e >= err_edge,
                   e >= mic, e >= mper, e >= dic, e >= dper};
      sb_q.push_back(t);
    end
  endtask

  task automatic at_negedge(input int n);
    int g;
    g = 0;
    @(negedge clk);
    while (edge_cnt != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("reach_edge", edge_cnt, n);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  // Scoreboard pop plus per-cycle polarity and release-order invariants
  always @(negedge clk) begin
    exp_t t;
    check("mem_per_polarity", mem_per_rst, !mem_per_n);
    check("des_per_polarity", des_per_rst, !des_per_n);
    check("des_ic_order", (des_ic_n && !mem_per_n), 0);
    check("des_per_order", (des_per_n && !mem_per_n), 0);
    if (rst_n && sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
      t = sb_q.pop_front();
      check($sformatf("seq_edge%0d", t.edge_n), obs_vec, t.exp_vec);
    end
  end

  initial begin
    host_if.i_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vec", obs_vec, 0);
    check("reset_hi", {mem_per_rst, des_per_rst}, 2'b11);

    // Power-on with calibration already done
    push_seq(1, 1'b0, 0, 0);
    rst_n = 1'b1;
    wait_drain(60);

    // Host request, then a second request mid-sequence that must be ignored
    req_edge = edge_cnt + 3;
    at_negedge(req_edge - 1);
    push_seq(req_edge, 1'b1, 0, 0);
    host_if.i_req = 1'b1;
    at_negedge(req_edge);
    host_if.i_req = 1'b0;
    at_negedge(req_edge + 6);
    host_if.i_req = 1'b1;
    @(negedge clk);
    host_if.i_req = 1'b0;
    wait_drain(60);

    // Calibration completing late at edge 20
    rst_n = 1'b0;
    calib = 1'b0;
    repeat (2) @(negedge clk);
    push_seq(1, 1'b0, 20, 0);
    rst_n = 1'b1;
    at_negedge(19);
    calib = 1'b1;
    wait_drain(60);

    // Calibration never completes
    rst_n = 1'b0;
    calib = 1'b0;
    repeat (2) @(negedge clk);
`ifdef RESET_SEQ_TIMEOUT_EN
    push_seq(1, 1'b0, -1, 0);
    rst_n = 1'b1;
    wait_drain(60);
    req_edge = edge_cnt + 3;
    at_negedge(req_edge - 1);
    push_seq(req_edge, 1'b1, -1, 0);
    host_if.i_req = 1'b1;
    at_negedge(req_edge);
    host_if.i_req = 1'b0;
    wait_drain(60);
`else
    push_seq(1, 1'b0, -1, 40);
    rst_n = 1'b1;
    wait_drain(80);
`endif

    // Async reset while in DES_IC, outputs must drop before any clock edge
    rst_n = 1'b0;
    calib = 1'b1;
    repeat (2) @(negedge clk);
    push_seq(1, 1'b0, 0, 10);
    rst_n = 1'b1;
    at_negedge(10);
    #1 rst_n = 1'b0;
    #1;
    check("async_vec", obs_vec, 0);
    check("async_hi", {mem_per_rst, des_per_rst}, 2'b11);
    check("async_drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    push_seq(1, 1'b0, 0, 0);
    rst_n = 1'b1;
    wait_drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
